// File: rtl/ascon_tx_serializer_if.sv
// ascon_tx_serializer_if: handshake and data bundle between the ASCON result path,
// the transmit serializer and the uart_core transmitter.
// The serializer uses the slave modport. The master modport is the environment side.
interface ascon_tx_serializer_if #(
  parameter int NBYTES_CIPHER = 184,
  parameter int NBYTES_TAG    = 16,
  parameter int NDBITS        = 8
);
  logic                       start_i;
  logic [NBYTES_CIPHER*8-1:0] cipher_i;
  logic [NBYTES_TAG*8-1:0]    tag_i;
  logic                       tx_busy_i;
  logic [NDBITS-1:0]          tx_byte_o;
  logic                       tx_load_o;
  logic                       busy_o;
  logic                       done_o;

  modport master (
    output start_i, cipher_i, tag_i, tx_busy_i,
    input  tx_byte_o, tx_load_o, busy_o, done_o
  );

  modport slave (
    input  start_i, cipher_i, tag_i, tx_busy_i,
    output tx_byte_o, tx_load_o, busy_o, done_o
  );
endinterface

// File: rtl/ascon_tx_serializer.sv
// ascon_tx_serializer: latches one cipher+tag frame on start and streams it
// MSB byte first into uart_core using the Din/LD/TxBusy handshake.
//
// Optional feature: define ASCON_TX_CHECKSUM_EN to append one XOR checksum
// byte covering all data bytes. Without the macro the frame is the data only.
//
// All outputs are registered. tx_load_o is high during the first WAIT_HI cycle.
// Frame bytes are NDBITS wide. The cipher and tag ports assume NDBITS == 8.
module ascon_tx_serializer #(
  parameter int NBYTES_CIPHER = 184,
  parameter int NBYTES_TAG    = 16,
  parameter int NDBITS        = 8
) (
  input  logic                        clock_i,
  input  logic                        resetb_i,
  ascon_tx_serializer_if.slave        bus
);

  localparam int NDATA = NBYTES_CIPHER + NBYTES_TAG;
  localparam int NBITS = NDATA * NDBITS;
`ifdef ASCON_TX_CHECKSUM_EN
  localparam int NFRAME = NDATA + 1;
  localparam logic [7:0] DATA_LEN = 8'(NDATA);
`else
  localparam int NFRAME = NDATA;
`endif
  localparam logic [7:0] FRAME_LEN = 8'(NFRAME);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LOAD    = 3'd1,
    S_WAIT_HI = 3'd2,
    S_WAIT_LO = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  state_t              state_q, state_d;
  logic [7:0]          cnt_q, cnt_d;
  logic [NBITS-1:0]    shreg_q, shreg_d;
  logic [NDBITS-1:0]   tx_byte_q, tx_byte_d;
  logic                tx_load_q, tx_load_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic [NDBITS-1:0]   next_byte_s;

`ifdef ASCON_TX_CHECKSUM_EN
  logic [NDBITS-1:0]   csum_q, csum_d;

  // Running checksum step: fold one transmitted byte into the accumulator.
  function automatic logic [NDBITS-1:0] csum_fold(input logic [NDBITS-1:0] acc,
                                                  input logic [NDBITS-1:0] b);
    return acc ^ b;
  endfunction

  // Byte to load: the data bytes come from the shift register, and the final byte is the checksum.
  always_comb begin
    next_byte_s = shreg_q[NBITS-1 -: NDBITS];
    if (cnt_q == DATA_LEN) begin
      next_byte_s = csum_q;
    end else begin
      next_byte_s = shreg_q[NBITS-1 -: NDBITS];
    end
  end
`else
  // Byte to load is always the top byte of the shift register.
  always_comb begin
    next_byte_s = shreg_q[NBITS-1 -: NDBITS];
  end
`endif

  // Next-state and output decode for the frame sequencer.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    shreg_d   = shreg_q;
    tx_byte_d = tx_byte_q;
    tx_load_d = 1'b0;
    busy_d    = busy_q;
    done_d    = 1'b0;
`ifdef ASCON_TX_CHECKSUM_EN
    csum_d    = csum_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (bus.start_i) begin
          shreg_d = {bus.cipher_i, bus.tag_i};
          cnt_d   = 8'd0;
          busy_d  = 1'b1;
          state_d = S_LOAD;
`ifdef ASCON_TX_CHECKSUM_EN
          csum_d  = {NDBITS{1'b0}};
`endif
        end else begin
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end
      end
      S_LOAD: begin
        tx_byte_d = next_byte_s;
        tx_load_d = 1'b1;
        state_d   = S_WAIT_HI;
`ifdef ASCON_TX_CHECKSUM_EN
        if (cnt_q < DATA_LEN) begin
          csum_d = csum_fold(csum_q, next_byte_s);
        end else begin
          csum_d = csum_q;
        end
`endif
      end
      S_WAIT_HI: begin
        // A busy flag that is already high in the first cycle counts as the acknowledge.
        if (bus.tx_busy_i) begin
          state_d = S_WAIT_LO;
        end else begin
          state_d = S_WAIT_HI;
        end
      end
      S_WAIT_LO: begin
        if (!bus.tx_busy_i) begin
          shreg_d = shreg_q << NDBITS;
          cnt_d   = cnt_q + 8'd1;
          if (cnt_d == FRAME_LEN) begin
            // Registered done and busy change together in the DONE cycle.
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = S_DONE;
          end else begin
            state_d = S_LOAD;
          end
        end else begin
          state_d = S_WAIT_LO;
        end
      end
      S_DONE: begin
        // A start in this cycle is dropped. The requester must retry from IDLE.
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  // Sequencer, shadow register and output flops with asynchronous clear.
  always_ff @(posedge clock_i or negedge resetb_i) begin
    if (!resetb_i) begin
      state_q   <= S_IDLE;
      cnt_q     <= 8'd0;
      shreg_q   <= {NBITS{1'b0}};
      tx_byte_q <= {NDBITS{1'b0}};
      tx_load_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      shreg_q   <= shreg_d;
      tx_byte_q <= tx_byte_d;
      tx_load_q <= tx_load_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

`ifdef ASCON_TX_CHECKSUM_EN
  // Checksum accumulator with asynchronous clear.
  always_ff @(posedge clock_i or negedge resetb_i) begin
    if (!resetb_i) begin
      csum_q <= {NDBITS{1'b0}};
    end else begin
      csum_q <= csum_d;
    end
  end
`endif

  assign bus.tx_byte_o = tx_byte_q;
  assign bus.tx_load_o = tx_load_q;
  assign bus.busy_o    = busy_q;
  assign bus.done_o    = done_q;

endmodule

// File: tb/tb_ascon_tx_serializer.sv
// tb_ascon_tx_serializer: directed self-checking bench for ascon_tx_serializer.
// A behavioural uart_core responder raises TxBusy after each load. A monitor
// captures the transmitted bytes and watches the handshake and busy_o.
module tb_ascon_tx_serializer;
  localparam int NC = 184;
  localparam int NT = 16;
  localparam int ND = 8;
`ifdef ASCON_TX_CHECKSUM_EN
  localparam int NF = NC + NT + 1;
`else
  localparam int NF = NC + NT;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ascon_tx_serializer_if #(.NBYTES_CIPHER(NC), .NBYTES_TAG(NT), .NDBITS(ND)) bus ();

  ascon_tx_serializer #(.NBYTES_CIPHER(NC), .NBYTES_TAG(NT), .NDBITS(ND)) dut (
    .clock_i  (clk),
    .resetb_i (rst_n),
    .bus      (bus)
  );

  int n_assert = 0;
  int n_fail   = 0;
  int lat_mode = 0;
  int n_done   = 0;
  int hs_err   = 0;
  int busy_err = 0;
  logic [7:0] cap_q[$];
  logic [7:0] exp_q[$];
  bit expect_ack = 1'b0;
  bit saw_hi     = 1'b0;
  bit in_frame   = 1'b0;
  bit ok;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive the input pattern and build the expected byte stream from the same formula.
  task automatic set_pattern(input int p);
    logic [7:0] b;
    logic [7:0] x;
    exp_q.delete();
    for (int k = 0; k < NC; k++) begin
      case (p)
        0:       b = 8'(k);
        1:       b = 8'h01;
        default: b = (k == 0) ? 8'h5A : 8'h00;
      endcase
      bus.cipher_i[(NC-1-k)*8 +: 8] = b;
      exp_q.push_back(b);
    end
    for (int k = 0; k < NT; k++) begin
      b = (p == 0) ? (8'hA0 + 8'(k)) : 8'h00;
      bus.tag_i[(NT-1-k)*8 +: 8] = b;
      exp_q.push_back(b);
    end
    x = 8'h00;
    foreach (exp_q[i]) x = x ^ exp_q[i];
`ifdef ASCON_TX_CHECKSUM_EN
    exp_q.push_back(x);
`endif
  endtask

  task automatic pulse_start();
    @(negedge clk);
    bus.start_i = 1'b1;
    @(negedge clk);
    bus.start_i = 1'b0;
  endtask

  task automatic wait_caps(input int n, input int max_cyc, output bit reached);
    reached = 1'b0;
    for (int c = 0; c < max_cyc; c++) begin
      if (cap_q.size() >= n) begin
        reached = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic wait_done(input int max_cyc, output bit seen);
    seen = 1'b0;
    for (int c = 0; c < max_cyc; c++) begin
      @(negedge clk);
      if (bus.done_o === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
  endtask

  task automatic check_frame(input string name);
    chk({name, "_len"}, cap_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < cap_q.size(); i++)
      chk($sformatf("%s_byte%0d", name, i), cap_q[i], exp_q[i]);
    chk({name, "_ndone"}, n_done, 1);
    chk({name, "_handshake"}, hs_err, 0);
    chk({name, "_busy"}, busy_err, 0);
  endtask

  task automatic run_frame(input string name);
    cap_q.delete();
    n_done = 0;
    pulse_start();
    wait_done(8000, ok);
    chk({name, "_done_seen"}, ok, 1'b1);
    chk({name, "_busy_in_done"}, bus.busy_o, 1'b0);
    @(negedge clk);
    chk({name, "_done_one_cycle"}, bus.done_o, 1'b0);
    check_frame(name);
  endtask

  // uart_core stand-in: TxBusy rises some cycles after each load and stays high 3 cycles.
  initial begin : uart_model
    bus.tx_busy_i = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.tx_load_o === 1'b1) begin
        int lat;
        if (lat_mode == 0) lat = 10;
        else begin
          case ($urandom_range(0, 2))
            0:       lat = 1;
            1:       lat = 2;
            default: lat = 5;
          endcase
        end
        repeat (lat - 1) @(negedge clk);
        bus.tx_busy_i = 1'b1;
        repeat (3) @(negedge clk);
        bus.tx_busy_i = 1'b0;
      end
    end
  end

  // Monitor: capture bytes, check load/busy alternation and busy_o coverage of the frame.
  initial begin : monitor
    forever begin
      @(posedge clk);
      #1;
      if (!rst_n) begin
        expect_ack = 1'b0;
        saw_hi     = 1'b0;
        in_frame   = 1'b0;
      end else begin
        if (bus.tx_load_o === 1'b1) begin
          if (expect_ack) hs_err++;
          expect_ack = 1'b1;
          saw_hi     = 1'b0;
          in_frame   = 1'b1;
          cap_q.push_back(bus.tx_byte_o);
        end else if (expect_ack && bus.tx_busy_i) begin
          saw_hi = 1'b1;
        end else if (expect_ack && saw_hi && !bus.tx_busy_i) begin
          expect_ack = 1'b0;
        end
        if (bus.done_o === 1'b1) begin
          n_done++;
          in_frame = 1'b0;
          if (bus.busy_o !== 1'b0) busy_err++;
        end else if (in_frame && bus.busy_o !== 1'b1) begin
          busy_err++;
        end
      end
    end
  end

  // Directed test sequence.
  initial begin : main
    bus.start_i = 1'b0;
    set_pattern(0);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_tx_byte", bus.tx_byte_o, 8'h00);
    chk("rst_tx_load", bus.tx_load_o, 1'b0);
    chk("rst_busy", bus.busy_o, 1'b0);
    chk("rst_done", bus.done_o, 1'b0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle_busy", bus.busy_o, 1'b0);

    // Full frame with latency and shadow-register checks.
    lat_mode = 0;
    cap_q.delete();
    n_done = 0;
    @(negedge clk);
    bus.start_i = 1'b1;
    @(negedge clk);
    bus.start_i = 1'b0;
    chk("lat_busy_n1", bus.busy_o, 1'b1);
    chk("lat_load_n1", bus.tx_load_o, 1'b0);
    bus.cipher_i = '1;
    @(negedge clk);
    chk("lat_load_n2", bus.tx_load_o, 1'b1);
    chk("lat_byte_n2", bus.tx_byte_o, 8'h00);
    wait_done(8000, ok);
    chk("frame1_done_seen", ok, 1'b1);
    chk("frame1_busy_in_done", bus.busy_o, 1'b0);
    @(negedge clk);
    chk("frame1_done_one_cycle", bus.done_o, 1'b0);
    chk("frame1_byte_held", bus.tx_byte_o, exp_q[NF-1]);
    check_frame("frame1");

    // Start while busy and in the done cycle is ignored.
    set_pattern(0);
    lat_mode = 1;
    cap_q.delete();
    n_done = 0;
    pulse_start();
    wait_caps(50, 4000, ok);
    chk("ign_reach50", ok, 1'b1);
    pulse_start();
    wait_done(8000, ok);
    chk("ign_done_seen", ok, 1'b1);
    bus.start_i = 1'b1;
    @(negedge clk);
    bus.start_i = 1'b0;
    repeat (20) @(negedge clk);
    chk("ign_busy_after", bus.busy_o, 1'b0);
    check_frame("ignored");

    // Fresh frame with randomized TxBusy latency of 1, 2 or 5 cycles.
    run_frame("random_hs");

    // Asynchronous reset in the middle of a frame.
    cap_q.delete();
    n_done = 0;
    pulse_start();
    wait_caps(100, 4000, ok);
    chk("rst_reach100", ok, 1'b1);
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_tx_byte", bus.tx_byte_o, 8'h00);
    chk("arst_tx_load", bus.tx_load_o, 1'b0);
    chk("arst_busy", bus.busy_o, 1'b0);
    chk("arst_done", bus.done_o, 1'b0);
    for (int c = 0; c < 50 && bus.tx_busy_i; c++) @(negedge clk);
    repeat (5) @(negedge clk);
    chk("arst_no_done", n_done, 0);
    rst_n = 1'b1;
    @(negedge clk);
    run_frame("after_rst");

`ifdef ASCON_TX_CHECKSUM_EN
    // Checksum byte values.
    set_pattern(1);
    run_frame("csum_ones");
    if (cap_q.size() == NF) chk("csum_ones_last", cap_q[NF-1], 8'h00);
    else chk("csum_ones_size", cap_q.size(), NF);
    set_pattern(2);
    run_frame("csum_5a");
    if (cap_q.size() == NF) chk("csum_5a_last", cap_q[NF-1], 8'h5A);
    else chk("csum_5a_size", cap_q.size(), NF);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
